// File: rtl/oam_write_buffer.sv
// oam_write_buffer: queues CPU sprite-word writes and drains them into OAM
// only while the PPU is in vblank, so CPU stores never collide with sprite fetch.
//
// Optional feature macro: OAM_BYPASS_EN
//   Defined   - a request that arrives while the queue is empty and vblank is
//               high skips the queue and is written to OAM at the next edge.
//   Undefined - every request goes through the queue.
//
// The OAM-side outputs (oam_we_o, oam_addr_o, oam_wdata_o, drain_done_o) are
// registered. full_o and empty_o are decoded combinationally from count_q.
// count_q is the only source of full/empty, so the read and write pointers
// can wrap freely.

module oam_write_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SPR_NUM_W = 6,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    oam_write_i,
    input  logic [SPR_NUM_W-1:0]    spr_num_i,
    input  logic [DATA_W-1:0]       spr_data_i,
    input  logic                    vblank_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic                    oam_we_o,
    output logic [SPR_NUM_W-1:0]    oam_addr_o,
    output logic [DATA_W-1:0]       oam_wdata_o,
    output logic                    drain_done_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = SPR_NUM_W + DATA_W;

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } state_e;

    // Queue storage: each entry is {sprite number, sprite word}
    logic [ENTRY_W-1:0]   mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    state_e               state_q, state_d;
    logic                 overflow_q, overflow_d;
    logic                 oam_we_q, oam_we_d;
    logic [SPR_NUM_W-1:0] oam_addr_q, oam_addr_d;
    logic [DATA_W-1:0]    oam_wdata_q, oam_wdata_d;
    logic                 drain_done_q, drain_done_d;

    logic                 full;
    logic                 empty;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   head;
    logic [SPR_NUM_W-1:0] head_addr;
    logic [DATA_W-1:0]    head_data;

    // Queue status and request classification, all judged on the pre-edge count
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
`ifdef OAM_BYPASS_EN
        // Queue empty in either state with vblank open: write OAM directly
        bypass = oam_write_i && empty && vblank_i;
`else
        bypass = 1'b0;
`endif
        // A same-cycle pop never frees room for a push into a full queue
        push      = oam_write_i && !full && !bypass;
        head      = mem_q[rd_ptr_q];
        head_addr = head[ENTRY_W-1:DATA_W];
        head_data = head[DATA_W-1:0];
    end

    // Drain FSM: decides when the head entry is popped into OAM
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        drain_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (vblank_i && !empty) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!vblank_i || empty) begin
                    // vblank closed: leftovers wait for the next vblank
                    state_d = StIdle;
                end else begin
                    pop = 1'b1;
                    if ((count_q == CNT_W'(1)) && !push) begin
                        state_d      = StIdle;
                        drain_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pointer, count and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (oam_write_i && full) begin
            overflow_d = 1'b1;
        end
    end

    // OAM port next-state: strobe only on a pop or a bypassed request
    always_comb begin
        oam_we_d    = pop || bypass;
        oam_addr_d  = oam_addr_q;
        oam_wdata_d = oam_wdata_q;
        if (pop) begin
            oam_addr_d  = head_addr;
            oam_wdata_d = head_data;
        end else if (bypass) begin
            oam_addr_d  = spr_num_i;
            oam_wdata_d = spr_data_i;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= StIdle;
            overflow_q   <= 1'b0;
            oam_we_q     <= 1'b0;
            oam_addr_q   <= '0;
            oam_wdata_q  <= '0;
            drain_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            oam_we_q     <= oam_we_d;
            oam_addr_q   <= oam_addr_d;
            oam_wdata_q  <= oam_wdata_d;
            drain_done_q <= drain_done_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {spr_num_i, spr_data_i};
        end
    end

    // Output drives
    always_comb begin
        full_o       = full;
        empty_o      = empty;
        count_o      = count_q;
        overflow_o   = overflow_q;
        oam_we_o     = oam_we_q;
        oam_addr_o   = oam_addr_q;
        oam_wdata_o  = oam_wdata_q;
        drain_done_o = drain_done_q;
    end

endmodule

// File: tb/tb_oam_write_buffer.sv
// Scoreboard bench for oam_write_buffer: the stimulus pushes expected OAM writes,
// and a negedge monitor pops and compares them whenever oam_we_o is high.
module tb_oam_write_buffer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned SPR_NUM_W = 6;
    localparam int unsigned DATA_W    = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   oam_write_i = 1'b0;
    logic [SPR_NUM_W-1:0]   spr_num_i = '0;
    logic [DATA_W-1:0]      spr_data_i = '0;
    logic                   vblank_i = 1'b0;
    logic                   full_o;
    logic                   empty_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;
    logic                   oam_we_o;
    logic [SPR_NUM_W-1:0]   oam_addr_o;
    logic [DATA_W-1:0]      oam_wdata_o;
    logic                   drain_done_o;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic [SPR_NUM_W+DATA_W-1:0] exp_q [$];

    oam_write_buffer #(
        .DEPTH     (DEPTH),
        .SPR_NUM_W (SPR_NUM_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .oam_write_i  (oam_write_i),
        .spr_num_i    (spr_num_i),
        .spr_data_i   (spr_data_i),
        .vblank_i     (vblank_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .oam_we_o     (oam_we_o),
        .oam_addr_o   (oam_addr_o),
        .oam_wdata_o  (oam_wdata_o),
        .drain_done_o (drain_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every OAM strobe must match the oldest expected write
    always @(negedge clk_i) begin
        if (oam_we_o) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL oam_unexpected: got addr=%0d data=%h, required no write",
                         oam_addr_o, oam_wdata_o);
            end else begin
                logic [SPR_NUM_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({oam_addr_o, oam_wdata_o} !== e) begin
                    failures++;
                    $display("FAIL oam_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             oam_addr_o, oam_wdata_o, e[DATA_W+SPR_NUM_W-1:DATA_W],
                             e[DATA_W-1:0]);
                end
            end
        end
        if (drain_done_o) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle request; scoreboard entry only when it should reach OAM
    task automatic push(input logic [SPR_NUM_W-1:0] n, input logic [DATA_W-1:0] d,
                        input bit reaches_oam);
        oam_write_i = 1'b1;
        spr_num_i   = n;
        spr_data_i  = d;
        if (reaches_oam) exp_q.push_back({n, d});
        tick();
        oam_write_i = 1'b0;
    endtask

    // Bounded wait for the queue to empty, then let the last strobe retire
    task automatic wait_empty(input string name);
        int n = 0;
        while (count_o != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (count_o != 0) begin
            failures++;
            $display("FAIL %s_timeout: got count=%0d, required 0", name, count_o);
        end
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int we0;
        int dn0;

        // 1. Reset state
        rst_i = 1'b1;
        tick();
        tick();
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_oam_we", 32'(oam_we_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_drain_done", 32'(drain_done_o), 0);
        rst_i = 1'b0;
        tick();

        // 2. Two entries queued outside vblank, then drained back-to-back
        vblank_i = 1'b0;
        push(6'd3, 32'h1122_3344, 1'b1);
        push(6'd7, 32'hAABB_CCDD, 1'b1);
        check("t2_count", 32'(count_o), 2);
        check("t2_we_idle", 32'(oam_we_o), 0);
        vblank_i = 1'b1;
        tick();
        check("t2_we_enter", 32'(oam_we_o), 0);
        tick();
        check("t2_we_first", 32'(oam_we_o), 1);
        check("t2_addr_first", 32'(oam_addr_o), 3);
        tick();
        check("t2_we_second", 32'(oam_we_o), 1);
        check("t2_addr_second", 32'(oam_addr_o), 7);
        check("t2_done", 32'(drain_done_o), 1);
        check("t2_count_end", 32'(count_o), 0);
        tick();
        check("t2_done_pulse", 32'(drain_done_o), 0);
        check("t2_we_end", 32'(oam_we_o), 0);
        vblank_i = 1'b0;
        tick();

        // 3. Fill to DEPTH, ninth write dropped, drain exactly DEPTH writes
        we0 = we_cnt;
        for (int i = 0; i < 8; i++) begin
            push(6'(10 + i), 32'hC0DE_0000 + 32'(i), 1'b1);
        end
        check("t3_full", 32'(full_o), 1);
        check("t3_overflow_pre", 32'(overflow_o), 0);
        push(6'd63, 32'hDEAD_BEEF, 1'b0);
        check("t3_overflow", 32'(overflow_o), 1);
        check("t3_count", 32'(count_o), 8);
        vblank_i = 1'b1;
        wait_empty("t3");
        vblank_i = 1'b0;
        check("t3_writes", 32'(we_cnt - we0), 8);
        check("t3_overflow_sticky", 32'(overflow_o), 1);
        check("t3_empty", 32'(empty_o), 1);

        // 4. Short vblank: two pops, then the rest on the next vblank
        for (int i = 0; i < 5; i++) begin
            push(6'(20 + i), 32'h4444_0000 + 32'(i), 1'b1);
        end
        we0 = we_cnt;
        dn0 = done_cnt;
        vblank_i = 1'b1;
        tick();
        tick();
        tick();
        vblank_i = 1'b0;
        tick();
        tick();
        check("t4_writes", 32'(we_cnt - we0), 2);
        check("t4_count", 32'(count_o), 3);
        check("t4_no_done", 32'(done_cnt - dn0), 0);
        vblank_i = 1'b1;
        wait_empty("t4b");
        vblank_i = 1'b0;
        check("t4_writes_total", 32'(we_cnt - we0), 5);
        check("t4_done", 32'(done_cnt - dn0), 1);

        // 5. Push every cycle while draining: count holds, pointers wrap
        for (int i = 0; i < 4; i++) begin
            push(6'(30 + i), 32'h5555_0000 + 32'(i), 1'b1);
        end
        vblank_i = 1'b1;
        tick();
        check("t5_count_start", 32'(count_o), 4);
        for (int i = 0; i < 6; i++) begin
            push(6'(40 + i), 32'h5555_1000 + 32'(i), 1'b1);
            check("t5_count_hold", 32'(count_o), 4);
        end
        wait_empty("t5");
        vblank_i = 1'b0;
        tick();

        // 6. Reset mid-drain discards the remaining entries
        we0 = we_cnt;
        push(6'd50, 32'h6666_0000, 1'b1);
        push(6'd51, 32'h6666_0001, 1'b1);
        push(6'd52, 32'h6666_0002, 1'b0);
        push(6'd53, 32'h6666_0003, 1'b0);
        push(6'd54, 32'h6666_0004, 1'b0);
        vblank_i = 1'b1;
        tick();
        tick();
        tick();
        check("t6_count_mid", 32'(count_o), 3);
        rst_i = 1'b1;
        tick();
        check("t6_rst_we", 32'(oam_we_o), 0);
        check("t6_rst_count", 32'(count_o), 0);
        check("t6_rst_overflow", 32'(overflow_o), 0);
        rst_i = 1'b0;
        tick();
        tick();
        check("t6_idle_we", 32'(oam_we_o), 0);
        check("t6_writes", 32'(we_cnt - we0), 2);

        // Single request with queue empty and vblank open
        push(6'd1, 32'h0101_0101, 1'b1);
`ifdef OAM_BYPASS_EN
        check("t6_bypass_we", 32'(oam_we_o), 1);
        check("t6_bypass_addr", 32'(oam_addr_o), 1);
        check("t6_bypass_count", 32'(count_o), 0);
        tick();
        check("t6_bypass_no_done", 32'(drain_done_o), 0);
`else
        check("t6_queued_count", 32'(count_o), 1);
        check("t6_queued_we", 32'(oam_we_o), 0);
        tick();
        tick();
        check("t6_queued_we_late", 32'(oam_we_o), 1);
        check("t6_queued_addr", 32'(oam_addr_o), 1);
`endif
        tick();
        tick();
        vblank_i = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
